// File: rtl/scoreboard_reg_file_pkg.sv
// Shared constants and sizing helpers for the scoreboarded register file.
package reg_file_pkg;

    localparam int WORD_LEN_DEF   = 32;
    localparam int WORD_COUNT_DEF = 16;

    // Address width never collapses to zero, even for a two-entry file.
    function automatic int addr_w(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    function automatic int cnt_max(input int pendW);
        return (1 << pendW) - 1;
    endfunction

endpackage

// File: rtl/scoreboard_reg_file_sb_counter.sv
// Per-register pending-write counter: clear wins, simultaneous inc/dec holds.
module sb_counter
    import reg_file_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              nz
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign nz = |cnt;

endmodule

// File: rtl/scoreboard_reg_file.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Build option: define SCOREBOARD_REG_FILE_BYPASS_EN for same-cycle writeback forwarding.
module scoreboard_reg_file
    import reg_file_pkg::*;
#(
    parameter int WORD_LEN   = WORD_LEN_DEF,
    parameter int WORD_COUNT = WORD_COUNT_DEF,
    parameter int READ_PORTS = 3,
    parameter int PEND_W     = 2,
    parameter int ZERO_LOCK  = 1,
    localparam int ADDR_W    = addr_w(WORD_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [READ_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [READ_PORTS*WORD_LEN-1:0] rd_data,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           issue_valid,
    input  logic [ADDR_W-1:0]              issue_addr,
    output logic                           issue_ready,
    input  logic                           wb_en,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [WORD_LEN-1:0]            wb_data,
    input  logic                           flush,
    output logic                           any_pending,
    output logic                           wb_err
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(cnt_max(PEND_W));

    logic [WORD_LEN-1:0]   regs [WORD_COUNT];
    logic [PEND_W-1:0]     cnt  [WORD_COUNT];
    logic [WORD_COUNT-1:0] nz;
    logic [WORD_COUNT-1:0] incVec;
    logic [WORD_COUNT-1:0] decVec;
    logic                  wbLocked;
    logic                  wbWrite;
    logic                  issueAccept;

    // Issue handshake: a transfer happens on a rising edge where issue_valid
    // and issue_ready are both 1; issue_ready looks at issue_addr's counter,
    // so it may change whenever issue_addr does.
    assign issue_ready = (cnt[issue_addr] != CNT_MAX) && !flush;
    assign issueAccept = issue_valid && issue_ready;

    assign wbLocked    = (ZERO_LOCK != 0) && (wb_addr == '0);
    assign wbWrite     = wb_en && !wbLocked;
    assign any_pending = |nz;

    for (genvar r = 0; r < WORD_COUNT; r++) begin : g_cnt
        assign incVec[r] = issueAccept && (issue_addr == ADDR_W'(r))
                           && !((ZERO_LOCK != 0) && (r == 0));
        assign decVec[r] = wbWrite && (wb_addr == ADDR_W'(r)) && nz[r];

        sb_counter #(.PEND_W(PEND_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (incVec[r]),
            .dec (decVec[r]),
            .clr (flush),
            .cnt (cnt[r]),
            .nz  (nz[r])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wbWrite) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // A retire with nothing outstanding is a decode/writeback bookkeeping bug;
    // during a flush the counters are being discarded, so it is not flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_err <= 1'b0;
        end else if (wbWrite && !nz[wb_addr] && !flush) begin
            wb_err <= 1'b1;
        end
    end

    // Register 0 is never written nor counted when locked, so it reads 0 / idle.
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] rdAddr;
        assign rdAddr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef SCOREBOARD_REG_FILE_BYPASS_EN
        localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
        logic hit;
        assign hit = wbWrite && (wb_addr == rdAddr);
        assign rd_data[k*WORD_LEN +: WORD_LEN] = hit ? wb_data : regs[rdAddr];
        assign rd_busy[k] = hit ? ((cnt[rdAddr] > CNT_ONE)
                                   || ((cnt[rdAddr] == CNT_ONE) && issueAccept
                                       && (issue_addr == rdAddr)))
                                : nz[rdAddr];
`else
        assign rd_data[k*WORD_LEN +: WORD_LEN] = regs[rdAddr];
        assign rd_busy[k] = nz[rdAddr];
`endif
    end

endmodule

// File: doc/scoreboard_reg_file.md
Name: scoreboard_reg_file

Overview:
- Parametrised successor to the core register file for the pipelined ARM datapath.
- N combinational read ports, one synchronous write port, and a per-register pending-write scoreboard.
- Decode issues destination registers and marks them pending; writeback clears them; hazard logic consumes the per-port busy flags.
- Sits between ID (reads/issue) and WB (write/retire); replaces the single-ported negedge-write file.

Parameters:
- WORD_LEN, 32, data width.
- WORD_COUNT, 16, number of registers; power of two, at least 2.
- READ_PORTS, 3, number of read ports (Rn, Rm, Rs).
- PEND_W, 2, width of each per-register pending counter; max outstanding writes per register = 2^PEND_W-1.
- ZERO_LOCK, 1, when 1 register 0 ignores writes and is never marked pending.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- rd_addr  in  READ_PORTS*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]. ADDR_W = clog2(WORD_COUNT).
- rd_data  out  READ_PORTS*WORD_LEN  packed read data.
- rd_busy  out  READ_PORTS  1 = the addressed register has a pending write.
- issue_valid  in  1  decode requests to mark issue_addr pending.
- issue_addr  in  ADDR_W  destination register being issued.
- issue_ready  out  1  issue will be accepted this cycle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADDR_W  writeback register.
- wb_data  in  WORD_LEN  writeback data.
- flush  in  1  pipeline flush; clears all pending counters.
- any_pending  out  1  OR of all counters being nonzero (registered state, combinational OR).
- wb_err  out  1  sticky flag: writeback retired a register whose counter was 0.

Behaviour:
- Reset (rst=0, async):
  - All registers 0, all counters 0, wb_err 0.
  - Hence rd_data 0, rd_busy 0, any_pending 0, issue_ready 1.
- Reads are combinational:
  - rd_data[k] = reg[rd_addr[k]].
  - rd_busy[k] = (cnt[rd_addr[k]] != 0).
  - With ZERO_LOCK=1, address 0 always reads 0 with busy 0.
- Write:
  - On posedge, if wb_en and not (ZERO_LOCK and wb_addr==0), reg[wb_addr] <= wb_data.
  - Write latency is 1 cycle; without bypass, a read of wb_addr sees the new value the cycle after.
- Issue handshake:
  - issue_ready = (cnt[issue_addr] != 2^PEND_W-1) and not flush.
  - Issue is accepted when issue_valid and issue_ready, so issue_ready depends on issue_addr.
  - With ZERO_LOCK=1, an issue to register 0 is accepted and has no effect.
- Counter update per register r at posedge:
  - inc = accepted issue to r; dec = wb_en to r with cnt[r] != 0.
  - inc and dec: counter unchanged.
  - inc only: +1.
  - dec only: -1.
  - Counter never wraps; saturation is prevented by issue_ready.
- Writeback to a register with cnt 0 (and not locked):
  - Data is still written and the counter stays 0.
  - wb_err <= 1 and stays 1 until reset.
- flush:
  - All counters <= 0 at posedge, overriding any inc or dec that cycle.
  - A writeback in the flush cycle still writes data and does not set wb_err.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- Multiple read ports addressing the same register return identical data and busy.

Optional Feature:
- Macro: SCOREBOARD_REG_FILE_BYPASS_EN.
- Defined:
  - When wb_en hits rd_addr[k] (not locked), rd_data[k] = wb_data in that same cycle.
  - rd_busy[k] is computed as if the decrement had already happened: busy only if cnt > 1, or cnt == 1 with a simultaneous accepted issue to that register.
- Undefined: reads return the stored value and busy reflects the current counter only, as described in Behaviour.

Decomposition:
- Package reg_file_pkg holds:
  - default constants WORD_LEN_DEF=32, WORD_COUNT_DEF=16;
  - function addr_w(count), which returns clog2(count) with a minimum of 1;
  - counter max helper cnt_max(pend_w).
- Sub-module sb_counter, one instance per register:
  - ports clk, rst, inc, dec, clr, cnt, nz;
  - an up/down counter with priority clr > inc/dec; inc and dec together hold the value.

Test Plan:
- Reset, then read all ports at addr 5 → rd_data=0, rd_busy=0, issue_ready=1, any_pending=0, wb_err=0.
- Issue r3; next cycle read r3 on port 1 → rd_busy[1]=1. Writeback r3=0xDEADBEEF → after the edge busy=0 and data=0xDEADBEEF; with BYPASS_EN, data and busy=0 in the writeback cycle itself.
- PEND_W=2: issue r4 three times → issue_ready=0 for addr 4 and a 4th issue is ignored. One writeback, then issue and writeback in the same cycle → counter stays 2.
- Issue r2, r7 → flush together with an issue to r9 → all busy=0, any_pending=0, r9 not pending.
- Writeback r6=0x1234 with no issue → r6 reads 0x1234 and wb_err=1, which persists until rst=0.
- ZERO_LOCK=1: issue r0 and writeback r0=0xFFFF → r0 reads 0, busy 0, wb_err stays 0. Assert rst mid-way between edges → all outputs return to reset values immediately.
